// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue slice.
// Optional feature macro used by this slice: FQ_MISALIGN_TRAP_EN.
package fetch_pkg;

    localparam int FQ_XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0) shown at the head while empty.
    localparam logic [FQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One queue entry; the FIFO stores it flattened as {instr, pc}.
    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pc;
    } fq_entry_t;

    // Occupancy counter width able to represent 0..depth.
    function automatic int fq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer with push/pop/clear and occupancy count.
// Push while full is accepted only together with a pop (the slot freed by
// the pop is the one being written). Clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [fq_cnt_w(DEPTH)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = fq_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Pointer advance modulo DEPTH (also correct for DEPTH == 1).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Qualify requests so the buffer can never underflow or overflow.
    always_comb begin
        do_pop_s  = pop & (count_r != {CW{1'b0}});
        do_push_s = push & ((count_r < CW'(DEPTH)) | do_pop_s);
    end

    // Entry storage; written at the tail on an accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !clear) begin
            mem_r[tail_r] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_pop_s) begin
                head_r <= ptr_inc(head_r);
            end else begin
                head_r <= head_r;
            end
            if (do_push_s) begin
                tail_r <= ptr_inc(tail_r);
            end else begin
                tail_r <= tail_r;
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign rdata = mem_r[head_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, imem request, redirect handling and a
// DEPTH-entry {instr, pc} queue feeding decode.
// Optional feature macro: FQ_MISALIGN_TRAP_EN (sticky misaligned-target trap).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [DATA_WIDTH-1:0]      PCF,
    input  logic                       ImemGntF,
    input  logic [DATA_WIDTH-1:0]      InstrF,
    input  logic                       RedirectE,
    input  logic [DATA_WIDTH-1:0]      TargetE,
    input  logic                       StallD,
    output logic                       ValidD,
    output logic [DATA_WIDTH-1:0]      InstrD,
    output logic [DATA_WIDTH-1:0]      PCD,
    output logic [DATA_WIDTH-1:0]      PCPlus4D,
`ifdef FQ_MISALIGN_TRAP_EN
    output logic                       MisalignF,
`endif
    output logic [fq_cnt_w(DEPTH)-1:0] CountQ
);

    localparam int CW = fq_cnt_w(DEPTH);
    localparam int EW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pcd_hold_r;
    logic [EW-1:0]         head_s;
    logic [CW-1:0]         count_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  space_s;
    logic                  fire_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic [DATA_WIDTH-1:0] instr_d_s;
    logic [DATA_WIDTH-1:0] pcd_s;
`ifdef FQ_MISALIGN_TRAP_EN
    logic                  misalign_r;
`endif

    // Handshake terms: decode pop, free slot, and accepted fetch.
    always_comb begin
        valid_s = (count_s != {CW{1'b0}});
        pop_s   = valid_s & ~StallD;
        space_s = (count_s < CW'(DEPTH)) | pop_s;
`ifdef FQ_MISALIGN_TRAP_EN
        fire_s   = ImemGntF & space_s & ~RedirectE & ~misalign_r;
        target_s = TargetE;
`else
        fire_s   = ImemGntF & space_s & ~RedirectE;
        target_s = {TargetE[DATA_WIDTH-1:2], 2'b00};
`endif
    end

    // PC register: redirect beats sequential advance; otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else if (RedirectE) begin
            pc_r <= target_s;
        end else if (fire_s) begin
            pc_r <= pc_r + DATA_WIDTH'(4);
        end else begin
            pc_r <= pc_r;
        end
    end

`ifdef FQ_MISALIGN_TRAP_EN
    // Sticky trap: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_r <= 1'b0;
        end else if (RedirectE) begin
            misalign_r <= (TargetE[1:0] != 2'b00);
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign MisalignF = misalign_r;
`endif

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fire_s),
        .pop   (pop_s),
        .clear (RedirectE),
        .wdata ({InstrF, pc_r}),
        .rdata (head_s),
        .count (count_s)
    );

    // Head view: NOP and the last shown PC while the queue is empty.
    always_comb begin
        if (valid_s) begin
            instr_d_s = head_s[EW-1:DATA_WIDTH];
            pcd_s     = head_s[DATA_WIDTH-1:0];
        end else begin
            instr_d_s = DATA_WIDTH'(NOP_INSTR);
            pcd_s     = pcd_hold_r;
        end
    end

    // Remember the PC presented to decode so it can be held while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcd_hold_r <= {DATA_WIDTH{1'b0}};
        end else begin
            pcd_hold_r <= pcd_s;
        end
    end

    assign PCF      = pc_r;
    assign ValidD   = valid_s;
    assign InstrD   = instr_d_s;
    assign PCD      = pcd_s;
    assign PCPlus4D = pcd_s + DATA_WIDTH'(4);
    assign CountQ   = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
// imem model: instruction at address A is A ^ 32'hC0DE_0000.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        ImemGntF;
    logic [31:0] InstrF;
    logic        RedirectE;
    logic [31:0] TargetE;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [2:0]  CountQ;
`ifdef FQ_MISALIGN_TRAP_EN
    logic        MisalignF;
`endif

    int tests_run;
    int tests_failed;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_queue #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PCF       (PCF),
        .ImemGntF  (ImemGntF),
        .InstrF    (InstrF),
        .RedirectE (RedirectE),
        .TargetE   (TargetE),
        .StallD    (StallD),
        .ValidD    (ValidD),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
`ifdef FQ_MISALIGN_TRAP_EN
        .MisalignF (MisalignF),
`endif
        .CountQ    (CountQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign InstrF = PCF ^ 32'hC0DE_0000;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pcf"},   PCF, 32'h0000_0000);
        chk({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
        chk({tag, "_count"}, {29'd0, CountQ}, 32'd0);
        chk({tag, "_instr"}, InstrD, NOP);
        chk({tag, "_pcd"},   PCD, 32'h0000_0000);
        chk({tag, "_pcp4"},  PCPlus4D, 32'h0000_0004);
`ifdef FQ_MISALIGN_TRAP_EN
        chk({tag, "_mis"},   {31'd0, MisalignF}, 32'd0);
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        ImemGntF  = 1'b0;
        RedirectE = 1'b0;
        TargetE   = 32'h0000_0000;
        StallD    = 1'b0;

        // Reset state
        #3;
        chk_reset_vals("rst");
        step();
        step();

        // Streaming with grant and no stall
        reset    = 1'b1;
        ImemGntF = 1'b1;
        chk("pre_valid", {31'd0, ValidD}, 32'd0);
        step();
        chk("s1_pcf",   PCF, 32'h0000_0004);
        chk("s1_valid", {31'd0, ValidD}, 32'd1);
        chk("s1_pcd",   PCD, 32'h0000_0000);
        chk("s1_instr", InstrD, imem(32'h0000_0000));
        chk("s1_count", {29'd0, CountQ}, 32'd1);
        step();
        chk("s2_pcf",   PCF, 32'h0000_0008);
        chk("s2_pcd",   PCD, 32'h0000_0004);
        chk("s2_pcp4",  PCPlus4D, 32'h0000_0008);
        chk("s2_count", {29'd0, CountQ}, 32'd1);
        step();
        chk("s3_pcd",   PCD, 32'h0000_0008);

        // Re-reset, then fill under stall
        reset = 1'b0;
        #1;
        chk_reset_vals("rst2");
        reset  = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("fill_count", {29'd0, CountQ}, 32'd4);
        chk("fill_pcf",   PCF, 32'h0000_0010);
        for (int i = 0; i < 6; i++) step();
        chk("hold_count", {29'd0, CountQ}, 32'd4);
        chk("hold_pcf",   PCF, 32'h0000_0010);
        chk("hold_pcd",   PCD, 32'h0000_0000);
        chk("hold_instr", InstrD, imem(32'h0000_0000));

        // Pop and push together at full
        StallD = 1'b0;
        step();
        chk("pp_count", {29'd0, CountQ}, 32'd4);
        chk("pp_pcf",   PCF, 32'h0000_0014);
        chk("pp_pcd",   PCD, 32'h0000_0004);

        // Drain: order 0x8, 0xC, 0x10, then empty
        ImemGntF = 1'b0;
        step();
        chk("dr1_pcd",   PCD, 32'h0000_0008);
        chk("dr1_count", {29'd0, CountQ}, 32'd3);
        step();
        chk("dr2_pcd",   PCD, 32'h0000_000C);
        chk("dr2_instr", InstrD, imem(32'h0000_000C));
        step();
        chk("dr3_pcd",   PCD, 32'h0000_0010);
        chk("dr3_instr", InstrD, imem(32'h0000_0010));
        chk("dr3_count", {29'd0, CountQ}, 32'd1);
        step();
        chk("emp_valid", {31'd0, ValidD}, 32'd0);
        chk("emp_instr", InstrD, NOP);
        chk("emp_pcd",   PCD, 32'h0000_0010);
        chk("emp_pcp4",  PCPlus4D, 32'h0000_0014);
        chk("emp_pcf",   PCF, 32'h0000_0014);

        // Redirect with three entries queued
        ImemGntF = 1'b1;
        StallD   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rd_count", {29'd0, CountQ}, 32'd3);
        chk("pre_rd_pcf",   PCF, 32'h0000_0020);
        RedirectE = 1'b1;
        TargetE   = 32'h0000_0100;
        StallD    = 1'b0;
        step();
        RedirectE = 1'b0;
        chk("rd1_valid", {31'd0, ValidD}, 32'd0);
        chk("rd1_count", {29'd0, CountQ}, 32'd0);
        chk("rd1_pcf",   PCF, 32'h0000_0100);
        chk("rd1_pcd",   PCD, 32'h0000_0014);
        chk("rd1_instr", InstrD, NOP);
        step();
        chk("rd2_valid", {31'd0, ValidD}, 32'd1);
        chk("rd2_pcd",   PCD, 32'h0000_0100);
        chk("rd2_instr", InstrD, imem(32'h0000_0100));
        chk("rd2_count", {29'd0, CountQ}, 32'd1);
        chk("rd2_pcf",   PCF, 32'h0000_0104);

        // Asynchronous reset mid-stream with two entries
        StallD = 1'b1;
        step();
        chk("mid_count", {29'd0, CountQ}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("arst");

        // PC wrap at the top of the address space
        #1;
        reset     = 1'b1;
        StallD    = 1'b0;
        RedirectE = 1'b1;
        TargetE   = 32'hFFFF_FFFC;
        step();
        RedirectE = 1'b0;
        chk("wr_pcf0", PCF, 32'hFFFF_FFFC);
        step();
        chk("wr_pcf1", PCF, 32'h0000_0000);
        chk("wr_pcd",  PCD, 32'hFFFF_FFFC);
        chk("wr_pcp4", PCPlus4D, 32'h0000_0000);
        step();
        chk("wr_pcd2", PCD, 32'h0000_0000);

        // Misaligned redirect target
        RedirectE = 1'b1;
        TargetE   = 32'h0000_0102;
        step();
        RedirectE = 1'b0;
`ifdef FQ_MISALIGN_TRAP_EN
        chk("ma_pcf",  PCF, 32'h0000_0102);
        chk("ma_flag", {31'd0, MisalignF}, 32'd1);
        step();
        chk("ma_hold_pcf",   PCF, 32'h0000_0102);
        chk("ma_hold_count", {29'd0, CountQ}, 32'd0);
        chk("ma_hold_flag",  {31'd0, MisalignF}, 32'd1);
        RedirectE = 1'b1;
        TargetE   = 32'h0000_0200;
        step();
        RedirectE = 1'b0;
        chk("ma_clr_flag", {31'd0, MisalignF}, 32'd0);
        chk("ma_clr_pcf",  PCF, 32'h0000_0200);
        step();
        chk("ma_res_pcf",   PCF, 32'h0000_0204);
        chk("ma_res_pcd",   PCD, 32'h0000_0200);
        chk("ma_res_count", {29'd0, CountQ}, 32'd1);
`else
        chk("al_pcf", PCF, 32'h0000_0100);
        step();
        chk("al_pcf2",  PCF, 32'h0000_0104);
        chk("al_pcd",   PCD, 32'h0000_0100);
        chk("al_instr", InstrD, imem(32'h0000_0100));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
